// File: rtl/coef_pingpong_buffer_pkg.sv
// Shared definitions for the ping-pong FIR coefficient buffer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package coef_pingpong_buffer_pkg;

    // Load/commit FSM states; the encoding is fixed so that state dumps
    // match the loader firmware's view of the block.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_FULL = 2'd2,
        S_PEND = 2'd3
    } state_t;

endpackage

// File: rtl/coef_pingpong_buffer_bank.sv
// One coefficient bank: DEPTH x WIDTH registers with a single indexed write port.
// Latency: a write is visible on data the cycle after we is sampled.
// Backpressure: none; the write is taken whenever we is high.
//
// Ports:
//   clk, reset        clock and asynchronous active-high reset (clears all entries)
//   we, waddr, wdata  write enable, entry index, coefficient value
//   data              all entries flattened, entry j at data[j*WIDTH +: WIDTH]
module coef_bank #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 4,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH*DEPTH-1:0] data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        data = '0;
        for (int j = 0; j < DEPTH; j++) begin
            data[j*WIDTH +: WIDTH] = mem[j];
        end
    end

endmodule

// File: rtl/coef_pingpong_buffer.sv
// Double-buffered FIR coefficient store: load the shadow bank, swap on a frame tick.
// Latency: dataout changes the cycle after the frame_tick edge that performs a swap.
// Backpressure: load_ready is high only while filling; beats offered otherwise are dropped.
//
// Ports:
//   clk, reset                       FIR clock, asynchronous active-high reset
//   load_start                       restart a shadow load from entry 0
//   load_valid, load_ready, load_data coefficient stream into the shadow bank
//   commit                           request a swap once the shadow bank is full
//   frame_tick                       sample boundary; the only point a swap happens
//   dataout                          active bank, coef j at dataout[j*WIDTH +: WIDTH]
//   active_bank                      which bank drives dataout
//   shadow_full                      shadow bank holds a complete set (FULL or PEND)
//   swap_done                        one-cycle pulse after a swap
//   err                              sticky protocol error, cleared by reset or load_start
module coef_pingpong_buffer
    import coef_pingpong_buffer_pkg::*;
#(
    parameter int WIDTH = 27,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_start,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [WIDTH-1:0]       load_data,
    input  logic                   commit,
    input  logic                   frame_tick,
    output logic [WIDTH*DEPTH-1:0] dataout,
    output logic                   active_bank,
    output logic                   shadow_full,
    output logic                   swap_done,
    output logic                   err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t                   state, state_nxt;
    logic [AW-1:0]            wptr, wptr_nxt;
    logic                     err_nxt;
    logic                     swap;
    logic                     wr_en;
    logic                     bank0_we, bank1_we;
    logic [WIDTH*DEPTH-1:0]   bank0_q, bank1_q;

    // State register plus the small amount of per-state bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            wptr        <= '0;
            err         <= 1'b0;
            active_bank <= 1'b0;
            swap_done   <= 1'b0;
        end else begin
            state       <= state_nxt;
            wptr        <= wptr_nxt;
            err         <= err_nxt;
            active_bank <= active_bank ^ swap;
            swap_done   <= swap;
        end
    end

    // Next-state logic. load_start takes priority over everything else it
    // can collide with, so a restarted load always begins clean.
    always_comb begin
        state_nxt = state;
        wptr_nxt  = wptr;
        err_nxt   = err;
        swap      = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_start) begin
                    state_nxt = S_FILL;
                    wptr_nxt  = '0;
                    err_nxt   = 1'b0;
                end else if (commit) begin
                    err_nxt = 1'b1;
                end
            end
            S_FILL: begin
                if (load_start) begin
                    // Restart; any beat offered this cycle is dropped.
                    wptr_nxt = '0;
                    err_nxt  = 1'b0;
                end else begin
                    if (load_valid) begin
                        if (wptr == LAST) begin
                            state_nxt = S_FULL;
                            wptr_nxt  = '0;
                        end else begin
                            wptr_nxt = wptr + 1'b1;
                        end
                    end
                    if (commit) begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_FULL: begin
                if (load_start) begin
                    state_nxt = S_FILL;
                    wptr_nxt  = '0;
                    err_nxt   = 1'b0;
                end else if (commit) begin
                    // A frame_tick in this same cycle is deliberately not
                    // used: the swap waits for the following tick.
                    state_nxt = S_PEND;
                end
            end
            S_PEND: begin
                if (frame_tick) begin
                    swap      = 1'b1;
                    state_nxt = S_IDLE;
                end
                if (load_start || commit) begin
                    err_nxt = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs and write steering. Writes always target the bank that is not
    // driving dataout, so the taps never see a partial set.
    always_comb begin
        load_ready  = (state == S_FILL);
        shadow_full = (state == S_FULL) || (state == S_PEND);
        wr_en       = load_ready && load_valid && !load_start;
        bank0_we    = wr_en &&  active_bank;
        bank1_we    = wr_en && !active_bank;
        dataout     = active_bank ? bank1_q : bank0_q;
    end

    coef_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) bank0 (
        .clk   (clk),
        .reset (reset),
        .we    (bank0_we),
        .waddr (wptr),
        .wdata (load_data),
        .data  (bank0_q)
    );

    coef_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) bank1 (
        .clk   (clk),
        .reset (reset),
        .we    (bank1_we),
        .waddr (wptr),
        .wdata (load_data),
        .data  (bank1_q)
    );

endmodule

// File: tb/tb_coef_pingpong_buffer.sv
// Testbench for coef_pingpong_buffer: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the two banks.
module tb_coef_pingpong_buffer;

    localparam int W = 27;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           load_start, load_valid, commit, frame_tick;
    logic [W-1:0]   load_data;
    logic           load_ready, active_bank, shadow_full, swap_done, err;
    logic [W*D-1:0] dataout;

    int tests = 0;
    int fails = 0;

    coef_pingpong_buffer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .commit      (commit),
        .frame_tick  (frame_tick),
        .dataout     (dataout),
        .active_bank (active_bank),
        .shadow_full (shadow_full),
        .swap_done   (swap_done),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Reference model: two coefficient sets, which one is live, and where
    // the loader is in its load/commit/wait-for-tick sequence.
    logic [W-1:0] mb [2][D];
    bit m_act, m_loading, m_full, m_pend, m_err, m_swap;
    int m_cnt;

    function automatic void model_reset();
        for (int b = 0; b < 2; b++)
            for (int j = 0; j < D; j++)
                mb[b][j] = '0;
        m_act = 0; m_loading = 0; m_full = 0; m_pend = 0;
        m_err = 0; m_swap = 0; m_cnt = 0;
    endfunction

    function automatic void model_update(bit ls, bit lv, bit cm, bit tk, logic [W-1:0] d);
        bit swap_now = 0;
        if (m_pend) begin
            if (tk) begin m_act = !m_act; m_pend = 0; swap_now = 1; end
            if (ls || cm) m_err = 1;
        end else if (m_full) begin
            if (ls) begin m_full = 0; m_loading = 1; m_cnt = 0; m_err = 0; end
            else if (cm) begin m_full = 0; m_pend = 1; end
        end else if (m_loading) begin
            if (ls) begin m_cnt = 0; m_err = 0; end
            else begin
                if (lv) begin
                    mb[m_act ? 0 : 1][m_cnt] = d;
                    m_cnt++;
                    if (m_cnt == D) begin m_loading = 0; m_full = 1; m_cnt = 0; end
                end
                if (cm) m_err = 1;
            end
        end else begin
            if (ls) begin m_loading = 1; m_cnt = 0; m_err = 0; end
            else if (cm) m_err = 1;
        end
        m_swap = swap_now;
    endfunction

    function automatic logic [W*D-1:0] exp_dout();
        logic [W*D-1:0] r;
        for (int j = 0; j < D; j++) r[j*W +: W] = mb[m_act ? 1 : 0][j];
        return r;
    endfunction

    function automatic logic [W*D-1:0] pack4(int c0, int c1, int c2, int c3);
        logic [W*D-1:0] r;
        r = '0;
        r[0*W +: W] = W'(c0);
        r[1*W +: W] = W'(c1);
        r[2*W +: W] = W'(c2);
        r[3*W +: W] = W'(c3);
        return r;
    endfunction

    task automatic check_w(input string tag, input logic [W*D-1:0] obs, input logic [W*D-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_b(input string tag, input logic obs, input logic expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        check_w("dataout",     dataout,     exp_dout());
        check_b("active_bank", active_bank, m_act);
        check_b("load_ready",  load_ready,  m_loading);
        check_b("shadow_full", shadow_full, m_full || m_pend);
        check_b("swap_done",   swap_done,   m_swap);
        check_b("err",         err,         m_err);
    endtask

    // One clock: drive at the falling edge, model the rising edge, check at
    // the next falling edge.
    task automatic step(input bit ls, input bit lv, input bit cm, input bit tk, input logic [W-1:0] d);
        load_start = ls; load_valid = lv; commit = cm; frame_tick = tk; load_data = d;
        @(posedge clk);
        model_update(ls, lv, cm, tk, d);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0);
    endtask

    task automatic load4(input int a, input int b, input int c, input int e);
        step(1, 0, 0, 0, '0);
        step(0, 1, 0, 0, W'(a));
        step(0, 1, 0, 0, W'(b));
        step(0, 1, 0, 0, W'(c));
        step(0, 1, 0, 0, W'(e));
    endtask

    initial begin
        reset = 1'b1;
        load_start = 0; load_valid = 0; commit = 0; frame_tick = 0; load_data = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        check_w("reset_dataout", dataout, '0);
        reset = 1'b0;
        idle();

        // Basic load, commit, swap.
        load4(1, 2, 3, 4);
        check_w("fill_keeps_old", dataout, '0);
        check_b("full_after_4", shadow_full, 1'b1);
        step(0, 0, 1, 0, '0);
        step(0, 0, 0, 1, '0);
        check_w("first_swap", dataout, pack4(1, 2, 3, 4));
        check_b("swap_pulse", swap_done, 1'b1);
        idle();
        check_b("swap_pulse_end", swap_done, 1'b0);

        // Commit during fill is an error; load_start clears it.
        step(1, 0, 0, 0, '0);
        step(0, 1, 0, 0, W'(11));
        step(0, 1, 0, 0, W'(12));
        step(0, 0, 1, 0, '0);
        check_b("commit_in_fill_err", err, 1'b1);
        check_b("still_filling", load_ready, 1'b1);
        step(1, 0, 0, 0, '0);
        check_b("err_cleared", err, 1'b0);

        // load_start on the third beat drops that beat.
        step(0, 1, 0, 0, W'(21));
        step(0, 1, 0, 0, W'(22));
        step(1, 1, 0, 0, W'(23));
        step(0, 1, 0, 0, W'(9));
        step(0, 1, 0, 0, W'(8));
        step(0, 1, 0, 0, W'(7));
        step(0, 1, 0, 0, W'(6));
        step(0, 0, 1, 0, '0);
        step(0, 0, 0, 1, '0);
        check_w("restart_swap", dataout, pack4(9, 8, 7, 6));
        check_b("back_to_bank0", active_bank, 1'b0);

        // commit with frame_tick: no swap until the next tick; load_start in PEND errs.
        load4(31, 32, 33, 34);
        step(0, 0, 1, 1, '0);
        check_b("no_early_swap", swap_done, 1'b0);
        check_w("no_early_data", dataout, pack4(9, 8, 7, 6));
        step(1, 0, 0, 0, '0);
        check_b("ls_in_pend_err", err, 1'b1);
        step(0, 0, 0, 1, '0);
        check_w("late_swap", dataout, pack4(31, 32, 33, 34));
        idle();

        // Asynchronous reset while a swap is pending.
        load4(41, 42, 43, 44);
        step(0, 0, 1, 0, '0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        check_w("async_reset_data", dataout, '0);
        @(negedge clk);
        reset = 1'b0;
        step(0, 0, 0, 1, '0);
        check_b("no_swap_after_reset", swap_done, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                 W'($urandom));
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
